output1_monitor: RTL

//  Downstream stage of the Circuit_A wrapper. Consumes the combinational Output1 signal (D & F),

---
 rtl/output1_monitor_pkg.sv | 45 ++++
 rtl/output1_monitor_sync_2ff.sv | 22 ++
 rtl/output1_monitor.sv | 66 ++++++
 3 files changed

// File: rtl/output1_monitor_pkg.sv
// Shared constants and the pattern-matcher step function for output1_monitor.
// The FSM state is the number of pattern bits matched so far (oldest bit first).
package output1_monitor_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_1    = 2'd1;
  localparam logic [1:0] S_10   = 2'd2;
  localparam logic [1:0] S_101  = 2'd3;

  localparam logic [3:0] PATTERN_DEF = 4'b1011;

  // Returns {hit, next_state}: hit when the full pattern has just completed, next_state
  // is the longest proper suffix of the seen bits that is still a pattern prefix.
  function automatic logic [2:0] pat_step(input logic [1:0] st, input logic b,
                                          input logic [3:0] pat);
    logic [3:0] seq;
    logic       hit;
    logic       ok;
    logic [1:0] nxt;
    int         len;
    len = int'(st) + 1;
    seq = 4'b0000;
    ok  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(st)) seq[i] = pat[3-i];
      else if (i == int'(st)) seq[i] = b;
    end
    hit = (len == 4);
    for (int i = 0; i < 4; i++) begin
      if (seq[i] != pat[3-i]) hit = 1'b0;
    end
    nxt = S_IDLE;
    for (int k = 1; k < 4; k++) begin
      if (k <= len) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (seq[len-k+j] != pat[3-j]) ok = 1'b0;
        end
        if (ok) nxt = 2'(k);
      end
    end
    return {hit, nxt};
  endfunction

endpackage

// File: rtl/output1_monitor_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with synchronous active-high reset to 0.
// Also used for the A..D switch inputs of the wrapper.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/output1_monitor.sv
// Synchronises Output1, counts its EN-qualified rising edges (saturating, sticky overflow)
// and flags completion of PATTERN on EN-strobed samples of Level.
//   state  | meaning
//   S_IDLE | no pattern prefix matched
//   S_1    | first pattern bit matched
//   S_10   | first two pattern bits matched
//   S_101  | first three pattern bits matched
module output1_monitor
  import output1_monitor_pkg::*;
#(
  parameter int         CNT_W   = 8,
  parameter logic [3:0] PATTERN = PATTERN_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Output1,
  input  logic             EN,
  input  logic             CLR,
  output logic             Level,
  output logic [CNT_W-1:0] Count,
  output logic             Overflow,
  output logic             Detect
);

  logic       level_s;
  logic       level_d;
  logic       rise;
  logic [1:0] state;
  logic [2:0] step;

  sync_2ff u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (Output1),
    .q   (level_s)
  );

  assign Level = level_s;
  assign rise  = level_s & ~level_d;
  assign step  = pat_step(state, level_s, PATTERN);

  // Edge history keeps running through CLR so a clear never fabricates a rise.
  always_ff @(posedge CLK) begin
    if (RST) level_d <= 1'b0;
    else     level_d <= level_s;
  end

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      Count    <= '0;
      Overflow <= 1'b0;
      state    <= S_IDLE;
      Detect   <= 1'b0;
    end else if (EN) begin
      if (rise) begin
        if (Count == '1) Overflow <= 1'b1;
        else             Count    <= Count + 1'b1;
      end
      state  <= step[1:0];
      Detect <= step[2];
    end else begin
      Detect <= 1'b0;
    end
  end

endmodule
